// File: rtl/vc_switch_arbiter_if.sv
// Request/grant bundle between the per-VC input buffers and one output-port arbiter.
// master drives requests and credit; slave is the arbiter that returns the grant.
interface vc_switch_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned INDEX_SIZE = $clog2(NUM_REQ),
    parameter int unsigned CNT_SIZE   = 8
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    tail;
    logic                  out_ready;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_valid;
    logic [INDEX_SIZE-1:0] grant_index;
    logic                  fire;
    logic [CNT_SIZE-1:0]   flit_cnt;

    modport master (
        output req,
        output tail,
        output out_ready,
        input  grant,
        input  grant_valid,
        input  grant_index,
        input  fire,
        input  flit_cnt
    );

    modport slave (
        input  req,
        input  tail,
        input  out_ready,
        output grant,
        output grant_valid,
        output grant_index,
        output fire,
        output flit_cnt
    );
endinterface

// File: rtl/vc_switch_arbiter.sv
// Round-robin, packet-locking arbiter for one router output port: a VC keeps the
// grant from its head flit until its tail flit transfers, so packets never interleave.
module vc_switch_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned INDEX_SIZE = $clog2(NUM_REQ),
    parameter int unsigned CNT_SIZE   = 8
) (
    input logic              clk,
    input logic              rst_n,
    vc_switch_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [INDEX_SIZE-1:0] ptr_q, ptr_d;
    logic [CNT_SIZE-1:0]   cnt_q, cnt_d;

    logic [INDEX_SIZE-1:0] grant_idx;
    logic [INDEX_SIZE-1:0] owner_next;
    logic [INDEX_SIZE-1:0] arb_start;
    logic [NUM_REQ-1:0]    cand;
    logic                  win_found;
    logic [INDEX_SIZE-1:0] win_idx;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [CNT_SIZE-1:0]   cnt_inc;
    logic                  fire;
    logic                  release_pkt;

    // One-hot to binary; yields 0 when there is no owner.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                grant_idx = grant_idx | INDEX_SIZE'(i);
            end
        end
    end

    assign fire        = (|(grant_q & bus.req)) & bus.out_ready;
    assign release_pkt = fire & (|(grant_q & bus.tail));
    assign owner_next  = (grant_idx == INDEX_SIZE'(NUM_REQ - 1)) ? '0
                                                                 : grant_idx + INDEX_SIZE'(1);

    // On release the departing owner is masked so its tail flit is not taken as a new head.
    assign arb_start = (state_q == StLocked) ? owner_next : ptr_q;
    assign cand      = (state_q == StLocked) ? (bus.req & ~grant_q) : bus.req;

    always_comb begin
        int unsigned           pos;
        logic [INDEX_SIZE-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(arb_start) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = INDEX_SIZE'(pos);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign win_onehot = NUM_REQ'(1) << win_idx;
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_SIZE'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StLocked;
                    grant_d = win_onehot;
                    cnt_d   = '0;
                end
            end
            StLocked: begin
                if (fire) begin
                    cnt_d = cnt_inc;
                end
                if (release_pkt) begin
                    ptr_d = owner_next;
                    if (win_found) begin
                        grant_d = win_onehot;
                        cnt_d   = '0;
                    end else begin
                        // Count of the finished packet stays visible while idle.
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_index = grant_idx;
    assign bus.fire        = fire;
    assign bus.flit_cnt    = cnt_q;

endmodule
